// File: rtl/hack_pkg.sv
// Shared encodings for the Hack control sequencer: FSM states and
// C-instruction field positions.
package hack_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int CINSTR_BIT = 15;
  localparam int JMP_BITS_MSB = 2;
  localparam int JMP_BITS_LSB = 0;
  localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of ROM handshake, ALU flags and PC control lines around the sequencer.
// The master side is the sequencer; the slave side is the surrounding CPU/ROM.
interface pc_sequencer_if;

  logic [15:0] instr;
  logic        instr_valid;
  logic        fetch_req;
  logic        zr;
  logic        ng;
  logic [15:0] a_reg;
  logic [15:0] pc_value;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_reset;
  logic [15:0] ir;
  logic        halted;
  logic [15:0] retired;

  modport master (
    input  instr, instr_valid, zr, ng, a_reg, pc_value,
    output fetch_req, pc_in, pc_load, pc_inc, pc_reset, ir, halted, retired
  );

  modport slave (
    output instr, instr_valid, zr, ng, a_reg, pc_value,
    input  fetch_req, pc_in, pc_load, pc_inc, pc_reset, ir, halted, retired
  );

endinterface

// File: rtl/pc_sequencer_jump_cond.sv
// Hack jump-condition decode: bit 2 = jump if negative, bit 1 = if zero,
// bit 0 = if strictly positive. A-instructions never jump.
module jump_cond (
  input  logic       is_c,
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       jump
);

  assign jump = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer producing the program counter's control inputs,
// with halt-idiom detection and a retired-instruction counter.
module pc_sequencer
  import hack_pkg::*;
#(
  parameter bit HALT_DETECT = 1'b1
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);

  state_e      state_r;
  state_e      state_next_s;
  logic [15:0] ir_r;
  logic [15:0] retired_r;
  logic        jump_s;
  logic        halt_hit_s;
  logic        fetch_dec_s;
  logic        load_dec_s;
  logic        inc_dec_s;
  logic        rst_dec_s;

  jump_cond u_jump_cond (
    .is_c (ir_r[CINSTR_BIT]),
    .jmp  (ir_r[JMP_BITS_MSB:JMP_BITS_LSB]),
    .zr   (bus.zr),
    .ng   (bus.ng),
    .jump (jump_s)
  );

  // A self-jump (0;JMP to the current PC) can never make progress, so park.
  assign halt_hit_s = (HALT_DETECT == 1'b1) && jump_s
                      && (ir_r[JMP_BITS_MSB:JMP_BITS_LSB] == JMP_ALWAYS)
                      && (bus.a_reg == bus.pc_value);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RST;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-state PC control decode
  always_comb begin
    state_next_s = state_r;
    fetch_dec_s  = 1'b0;
    load_dec_s   = 1'b0;
    inc_dec_s    = 1'b0;
    rst_dec_s    = 1'b0;
    case (state_r)
      ST_RST: begin
        rst_dec_s    = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_dec_s = 1'b1;
        if (bus.instr_valid) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        load_dec_s = jump_s;
        inc_dec_s  = ~jump_s;
        if (halt_hit_s) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_RST;
      end
    endcase
  end

  // Instruction latch and retired counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_r      <= 16'h0000;
      retired_r <= 16'h0000;
    end else begin
      if ((state_r == ST_FETCH) && bus.instr_valid) begin
        ir_r <= bus.instr;
      end
      if (state_r == ST_EXEC) begin
        retired_r <= retired_r + 16'd1;
      end
    end
  end

  // While reset is held the PC is cleared regardless of the state being left.
  assign bus.pc_reset  = reset | rst_dec_s;
  assign bus.fetch_req = ~reset & fetch_dec_s;
  assign bus.pc_load   = ~reset & load_dec_s;
  assign bus.pc_inc    = ~reset & inc_dec_s;
  assign bus.pc_in     = bus.a_reg;
  assign bus.ir        = ir_r;
  assign bus.retired   = retired_r;
  assign bus.halted    = (state_r == ST_HALT);

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control sequencer that drives the program counter's `in`/`load`/`inc`/`reset` control inputs, producing their values rather than consuming them. Runs a fetch/execute loop against an instruction ROM with a valid handshake and decodes Hack C-instruction jump bits against ALU flags to select load versus increment. Detects the canonical `@self; 0;JMP` halt idiom and parks. Keeps a retired-instruction count for debug.

## Interface
- `HALT_DETECT`, default 1: 1 enables halt detection; 0 treats a self-jump as an ordinary jump.
- `clk` input, 1 bit: the only clock; everything is rising-edge.
- `reset` input, 1 bit: synchronous, active-high.
- `instr` input, 16 bits: ROM data for the current PC address.
- `instr_valid` input, 1 bit: `instr` is valid this cycle.
- `fetch_req` output, 1 bit: sequencer is waiting for an instruction.
- `zr`, `ng` inputs, 1 bit each: ALU flags for the latched instruction, valid in EXEC.
- `a_reg` input, 16 bits: A register, the jump target.
- `pc_value` input, 16 bits: current PC output, used for halt detection.
- `pc_in` output, 16 bits: load value for the PC.
- `pc_load`, `pc_inc`, `pc_reset` outputs, 1 bit each: PC controls.
- `ir` output, 16 bits: latched instruction.
- `halted` output, 1 bit: sequencer is in HALT.
- `retired` output, 16 bits: count of executed instructions.

## Operation
States are RST, FETCH, EXEC and HALT.
- **RST:** `pc_reset`=1; all other PC controls 0. Next state is FETCH.
- **FETCH:** `fetch_req`=1.
  - If `instr_valid`=1: `ir`<=`instr`, then go to EXEC.
  - Otherwise stay in FETCH with no stall limit.
- **EXEC:** computes `jump`.
  - If `ir[15]`=0 (A-instruction), `jump`=0.
  - Otherwise `jump` = (`ir[2]`&`ng`) | (`ir[1]`&`zr`) | (`ir[0]`&~`ng`&~`zr`).
  - `pc_load`=`jump`, `pc_inc`=~`jump`, `pc_in`=`a_reg`.
  - `retired` increments by 1, modulo 2^16, so 0xFFFF wraps to 0x0000.
  - Next state is HALT if all of these hold: `HALT_DETECT`=1, `jump`=1, `ir[2:0]`=3'b111, and `a_reg`==`pc_value`. Otherwise next state is FETCH.
- **HALT:** `halted`=1; `pc_load`=`pc_inc`=`pc_reset`=0 and `fetch_req`=0. Only `reset` leaves HALT.
- Outside FETCH and EXEC: `pc_load`=`pc_inc`=0 and `pc_in`=`a_reg`.
- `instr_valid` outside FETCH is ignored; `ir` is not modified.
- Flags `zr` and `ng` are sampled only in EXEC. At most one of `pc_load`, `pc_inc`, `pc_reset` is high in any cycle.

## Timing
- **Reset:** `reset`=1 at an edge forces the next state to RST from any state, including mid-FETCH or mid-EXEC.
  - Registers clear: `ir`=0x0000, `retired`=0x0000, `halted`=0.
  - During the cycle(s) `reset` is high, outputs are `pc_reset`=1, `fetch_req`=0, `pc_load`=0, `pc_inc`=0.
  - First FETCH is the cycle after the RST cycle following deassertion.
- **Output paths:** `pc_load`, `pc_inc` and `pc_in` are combinational from state, `ir`, flags and `a_reg`. The PC register samples them at the edge that ends EXEC.
- **Throughput:** 2 cycles per instruction with a zero-wait ROM (`instr_valid` high in the first FETCH cycle). A ROM wait of N cycles gives N+2.
- **Halt entry:** the PC is loaded with `a_reg` (unchanged value) on the EXEC→HALT edge. `halted` rises the following cycle.

## Structure
- **Shared package `hack_pkg`:** state encoding (RST, FETCH, EXEC, HALT, 2 bits); `JMP_BITS` = positions [2:0]; `CINSTR_BIT` = 15; `JMP_ALWAYS` = 3'b111.
- **Sub-module `jump_cond`** (combinational): inputs `ir[15]`, `ir[2:0]`, `zr`, `ng`; output `jump`. It is reused by the CPU model in the testbench.
- The FSM, `ir` register and `retired` counter live in `pc_sequencer`.

## Test plan
- **Reset, zero-wait ROM, A-instruction:** after reset, `instr`=0x0005 with `instr_valid` held high → cycle sequence RST, FETCH, EXEC. `ir`=0x0005, `pc_inc`=1 in EXEC, `retired`=1.
- **Jump decode sweep:** `ir`=0xE302 (JEQ) with `zr`=1 → `pc_load`=1, `pc_in`=`a_reg`=0x0010. Repeat with `zr`=0 → `pc_inc`=1. Sweep all 8 jump codes × three flag combos (`zr`/`ng` = 10, 01, 00) against a reference model.
- **ROM stall:** `instr_valid` low for 3 FETCH cycles → `fetch_req` stays 1 and `ir` is unchanged. Pulsing `instr_valid` during EXEC leaves `ir` unaltered.
- **Halt:** `pc_value`=0x0007, `a_reg`=0x0007, `ir`=0xEA87 (0;JMP) → `pc_load`=1 in EXEC, then `halted`=1 and all PC controls 0 indefinitely.
  - With `HALT_DETECT`=0, the same stimulus returns to FETCH.
- **Reset mid-operation:** assert `reset` during EXEC with `ir`=0xE307 → next cycle `pc_reset`=1, `pc_load`=0, `ir`=0, `retired`=0. Normal fetch resumes after deassertion.
- **Counter wrap:** preload `retired` to 0xFFFF via 65535 executed A-instructions (or a forced value in the bench) → the next EXEC yields 0x0000.
